// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: handshake and status bundle for fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
// With FIFO_SYNC_ERR_EN defined the bundle also carries err_clr, overflow and underflow.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  fifo_count;
`ifdef FIFO_SYNC_ERR_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output wr_en, data_in, rd_en,
`ifdef FIFO_SYNC_ERR_EN
    output err_clr,
    input  overflow, underflow,
`endif
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, fifo_count
  );

  modport slave (
    input  wr_en, data_in, rd_en,
`ifdef FIFO_SYNC_ERR_EN
    input  err_clr,
    output overflow, underflow,
`endif
    output data_out, rd_valid, full, empty, almost_full, almost_empty, fifo_count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with any depth >= 2.
// Status flags are decoded straight from the occupancy register, so they
// track the count with no lag. Read data is registered and qualified by a
// one-cycle rd_valid pulse. There is no write-to-read bypass.
// Optional feature macro FIFO_SYNC_ERR_EN: sticky overflow/underflow flags
// cleared by err_clr (a new error in the clearing cycle wins).
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  fifo_sync_param_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_acc;
  logic              wr_acc;

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc = bus.rd_en && (count != '0);
    wr_acc = bus.wr_en && ((count != FULL_CNT) || rd_acc);
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers wrap by explicit compare so non-power-of-2 depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous read and write leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count <= count - CNT_W'(1);
    end
  end

  // Registered read port; data_out holds between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_acc;
      if (rd_acc) bus.data_out <= mem[rd_ptr];
    end
  end

  assign bus.fifo_count   = count;
  assign bus.full         = (count == FULL_CNT);
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);

`ifdef FIFO_SYNC_ERR_EN
  // Sticky error flags; setting has priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.wr_en && !wr_acc) bus.overflow <= 1'b1;
      else if (bus.err_clr)     bus.overflow <= 1'b0;
      if (bus.rd_en && !rd_acc) bus.underflow <= 1'b1;
      else if (bus.err_clr)     bus.underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: two FIFO instances (8 deep, and 5 deep with AF=4/AE=1)
// checked cycle by cycle against a queue-based reference model.
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(8)) b8 ();
  fifo_sync_param_if #(.DATA_W(8), .DEPTH(5)) b5 ();

  fifo_sync_param #(.DATA_W(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave)
  );
  fifo_sync_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(b5.slave)
  );

  // reference model state, index 0 = 8-deep, index 1 = 5-deep
  int         depth_m [2] = '{8, 5};
  int         af_m    [2] = '{6, 4};
  int         ae_m    [2] = '{2, 1};
  logic [7:0] q8 [$];
  logic [7:0] q5 [$];
  logic [7:0] exp_dout [2];
  bit         exp_ov [2];
  bit         exp_uf [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    b8.wr_en = 1'b0; b8.rd_en = 1'b0; b8.data_in = '0;
    b5.wr_en = 1'b0; b5.rd_en = 1'b0; b5.data_in = '0;
`ifdef FIFO_SYNC_ERR_EN
    b8.err_clr = 1'b0; b5.err_clr = 1'b0;
`endif
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q8.size() : q5.size();
  endfunction

  task automatic model_reset();
    q8.delete();
    q5.delete();
    for (int i = 0; i < 2; i++) begin
      exp_dout[i] = '0;
      exp_ov[i] = 1'b0;
      exp_uf[i] = 1'b0;
    end
  endtask

  // Compare every output of one instance against the model.
  task automatic check_outputs(input int sel, input bit exp_valid, input string tag);
    int n;
    logic [31:0] o_dout, o_valid, o_cnt, o_full, o_empty, o_af, o_ae;
    n = qsize(sel);
    if (sel == 0) begin
      o_dout = 32'(b8.data_out); o_valid = 32'(b8.rd_valid); o_cnt = 32'(b8.fifo_count);
      o_full = 32'(b8.full); o_empty = 32'(b8.empty);
      o_af = 32'(b8.almost_full); o_ae = 32'(b8.almost_empty);
    end else begin
      o_dout = 32'(b5.data_out); o_valid = 32'(b5.rd_valid); o_cnt = 32'(b5.fifo_count);
      o_full = 32'(b5.full); o_empty = 32'(b5.empty);
      o_af = 32'(b5.almost_full); o_ae = 32'(b5.almost_empty);
    end
    chk({tag, "_data_out"}, o_dout, 32'(exp_dout[sel]));
    chk({tag, "_rd_valid"}, o_valid, 32'(exp_valid));
    chk({tag, "_count"}, o_cnt, 32'(n));
    chk({tag, "_full"}, o_full, 32'(n == depth_m[sel]));
    chk({tag, "_empty"}, o_empty, 32'(n == 0));
    chk({tag, "_almost_full"}, o_af, 32'(n >= af_m[sel]));
    chk({tag, "_almost_empty"}, o_ae, 32'(n <= ae_m[sel]));
`ifdef FIFO_SYNC_ERR_EN
    if (sel == 0) begin
      chk({tag, "_overflow"}, 32'(b8.overflow), 32'(exp_ov[0]));
      chk({tag, "_underflow"}, 32'(b8.underflow), 32'(exp_uf[0]));
    end else begin
      chk({tag, "_overflow"}, 32'(b5.overflow), 32'(exp_ov[1]));
      chk({tag, "_underflow"}, 32'(b5.underflow), 32'(exp_uf[1]));
    end
`endif
  endtask

  // One clock of stimulus on instance sel, model update, then full output check.
  task automatic cyc(input int sel, input bit wr, input logic [7:0] din, input bit rd,
                     input bit clr, input string tag);
    int n;
    bit racc, wacc;
    logic [7:0] popped;
    idle_inputs();
    if (sel == 0) begin
      b8.wr_en = wr; b8.rd_en = rd; b8.data_in = din;
`ifdef FIFO_SYNC_ERR_EN
      b8.err_clr = clr;
`endif
    end else begin
      b5.wr_en = wr; b5.rd_en = rd; b5.data_in = din;
`ifdef FIFO_SYNC_ERR_EN
      b5.err_clr = clr;
`endif
    end
    n = qsize(sel);
    racc = rd && (n != 0);
    wacc = wr && ((n != depth_m[sel]) || racc);
    if (racc) begin
      if (sel == 0) popped = q8.pop_front();
      else          popped = q5.pop_front();
      exp_dout[sel] = popped;
    end
    if (wacc) begin
      if (sel == 0) q8.push_back(din);
      else          q5.push_back(din);
    end
    if (wr && !wacc) exp_ov[sel] = 1'b1;
    else if (clr)    exp_ov[sel] = 1'b0;
    if (rd && !racc) exp_uf[sel] = 1'b1;
    else if (clr)    exp_uf[sel] = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(sel, racc, tag);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    idle_inputs();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs(0, 1'b0, {tag, "8"});
    check_outputs(1, 1'b0, {tag, "5"});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    idle_inputs();
    model_reset();
    #2;
    check_outputs(0, 1'b0, "rst8");
    check_outputs(1, 1'b0, "rst5");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill 0x11..0x88 then drain in order
    for (int i = 1; i <= 8; i++) cyc(0, 1'b1, 8'(i * 8'h11), 1'b0, 1'b0, "fill");
    chk("fill_full", 32'(b8.full), 32'd1);
    chk("fill_count", 32'(b8.fifo_count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
      chk("drain_word", 32'(b8.data_out), 32'(i * 8'h11));
    end
    chk("drain_empty", 32'(b8.empty), 32'd1);

    // overflow on a full FIFO, then clear
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "refill");
    cyc(0, 1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
    cyc(0, 1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");

    // full with simultaneous read/write streaming across pointer wrap
    for (int i = 0; i < 20; i++) cyc(0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "stream");
    for (int i = 0; i < 8; i++) cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "stream_drain");

    // empty with read and write together: read rejected, no bypass
    cyc(0, 1'b1, 8'h5C, 1'b1, 1'b0, "empty_rw");
    chk("empty_rw_count", 32'(b8.fifo_count), 32'd1);
    cyc(0, 1'b0, 8'h00, 1'b1, 1'b1, "empty_rw_read");
    chk("empty_rw_data", 32'(b8.data_out), 32'h5C);

    // 5-deep instance: writes with interleaved reads, pointer wrap at 4->0
    for (int i = 0; i < 12; i++)
      cyc(1, 1'b1, 8'(8'h20 + i), (i % 3 == 2), 1'b0, "d5_mix");
    for (int i = 0; i < 6; i++) cyc(1, 1'b0, 8'h00, 1'b1, 1'b0, "d5_drain");

    // randomized traffic, write-heavy then read-heavy phases, both instances
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 400; i++) begin
        int wp;
        wp = (i < 200) ? 70 : 30;
        d = 8'($urandom_range(0, 255));
        cyc(sel, ($urandom_range(0, 99) < wp), d, ($urandom_range(0, 99) < (100 - wp)),
            ($urandom_range(0, 7) == 0), (sel == 0) ? "rnd8" : "rnd5");
      end
    end

    // mid-operation asynchronous reset discards contents
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, "pre_rst");
    async_reset("mid_rst");
    cyc(0, 1'b1, 8'h3C, 1'b0, 1'b0, "post_rst_wr");
    cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");
    chk("post_rst_data", 32'(b8.data_out), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO. Next generation of the team's fixed 8x8 synchronous FIFO.
- Adds configurable width and depth, non-power-of-2 depth support, and combinational full/empty flags with no lag.
- Adds programmable almost-full/almost-empty thresholds, a read-data valid strobe, and optional sticky error flags.
- Sits between producer/consumer datapaths in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 8, number of storage entries (>=2; any integer, not restricted to a power of 2)
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- CNT_W, $clog2(DEPTH+1), width of fifo_count (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  data_out updated this cycle (1-cycle pulse)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- fifo_count  out  CNT_W  current occupancy, 0..DEPTH
- err_clr  in  1  clears sticky errors (only with FIFO_SYNC_ERR_EN)
- overflow  out  1  sticky: write rejected (only with FIFO_SYNC_ERR_EN)
- underflow  out  1  sticky: read rejected (only with FIFO_SYNC_ERR_EN)

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - data_out=0, rd_valid=0, overflow=0, underflow=0.
  - Storage array is not reset.
- Accept rules, evaluated on the current registered count:
  - rd_acc = rd_en & (count != 0)
  - wr_acc = wr_en & ((count != DEPTH) | rd_acc)
- Full with rd_en & wr_en: both accepted, count stays DEPTH.
- Empty with rd_en & wr_en: read rejected, write accepted, count goes to 1. There is no bypass; the new word is readable on the next cycle.
- Write: mem[wr_ptr] <= data_in. wr_ptr increments, wrapping DEPTH-1 -> 0 (explicit compare, not a modulo of the pointer width).
- Read:
  - data_out <= mem[rd_ptr] and rd_ptr increments with the same wrap rule.
  - rd_valid=1 in the following cycle, so data is valid one clock after rd_en is accepted.
  - data_out holds its value when no read is accepted.
- Count update per cycle:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
  - Count never leaves 0..DEPTH.
- full, empty, almost_full, almost_empty: combinational decodes of the count register. They are valid in the same cycle the count changes, with no extra register stage.
- fifo_count = count register.
- Ordering is strict FIFO; words read in the same order as written across pointer wrap.
- Mid-operation reset discards contents; the first post-reset read returns the first post-reset write.

Optional Feature:
- Macro: FIFO_SYNC_ERR_EN
- Defined:
  - overflow sets on any cycle with wr_en & !wr_acc.
  - underflow sets on any cycle with rd_en & !rd_acc.
  - Both hold until a cycle with err_clr=1, which clears them; a new error in that same cycle wins (set priority).
  - Both clear on reset.
- Undefined: err_clr, overflow and underflow ports and logic are absent. Rejected requests are silently dropped.

Test Plan:
- DEPTH=8, DATA_W=8: write 0x11..0x88 -> full=1, fifo_count=8, almost_full=1. Then 8 reads -> data_out 0x11..0x88 in order, each with rd_valid one cycle after its read, then empty=1.
- Full FIFO, wr_en=1 with rd_en=0 and data 0xAA -> count stays 8, 0xAA never read out, overflow=1 (macro on). Then err_clr pulse -> overflow=0.
- Full FIFO, rd_en=wr_en=1 for 20 cycles with an incrementing pattern -> count stays 8, output stream continuous and in order across wrap.
- Empty FIFO, rd_en=wr_en=1 with 0x5C -> rd_valid=0, count=1, underflow=1. Next cycle rd_en -> data_out=0x5C.
- DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: 12 writes with interleaved reads -> correct wrap at 4->0, almost_full exactly when count>=4, almost_empty exactly when count<=1.
- Fill with 3 words, assert rst_n low mid-cycle (asynchronous) -> flags and count go to 0 immediately. Next write 0x3C then read -> data_out=0x3C.
